// File: rtl/color_scan_sequencer.sv
// TCS3200 scan controller: steps the filters through red/green/blue/clear, counts sensor edges
// in a gate window per filter, and publishes the four counts as one coherent set.
module color_scan_sequencer #(
    parameter int         SETTLE_CYCLES = 50000,
    parameter int         GATE_CYCLES   = 500000,
    parameter int         CNT_W         = 16,
    parameter logic [1:0] SCALE         = 2'b11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic             sensor_out,
    output logic [1:0]       s2_s3,
    output logic [1:0]       s0_s1,
    output logic             led_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic [3:0]       sat
);
    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [1:0] CH_RED   = 2'd0;
    localparam logic [1:0] CH_CLEAR = 2'd3;

    // IDLE: sensor powered down | SETTLE: filter settling | GATE: counting edges | DONE: publish
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_GATE, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            ch_q, ch_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0]      edge_cnt_q, edge_cnt_d, edge_cnt_nxt;
    logic [3:0][CNT_W-1:0] shd_q, shd_d, pub_q, pub_d;
    logic [3:0]            shd_sat_q, shd_sat_d, sat_q, sat_d;
    logic [2:0]            sync_q, sync_d;
    logic                  edge_q, edge_d;
    logic [1:0]            s2_s3_q, s2_s3_d, s0_s1_q, s0_s1_d;
    logic                  led_en_q, led_en_d, busy_q, busy_d, done_q, done_d;

    function automatic logic [1:0] chan_code(input logic [1:0] ch);
        case (ch)
            2'd0:    return 2'b00;
            2'd1:    return 2'b11;
            2'd2:    return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    always_comb begin
        sync_d     = {sync_q[1:0], sensor_out};
        edge_d     = sync_q[1] & ~sync_q[2];
        state_d    = state_q;
        ch_d       = ch_q;
        tmr_d      = tmr_q;
        edge_cnt_d = edge_cnt_q;
        shd_d      = shd_q;
        shd_sat_d  = shd_sat_q;
        pub_d      = pub_q;
        sat_d      = sat_q;

        edge_cnt_nxt = edge_cnt_q;
        if (edge_q && edge_cnt_q != CNT_MAX)
            edge_cnt_nxt = edge_cnt_q + CNT_W'(1);

        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_SETTLE;
                        ch_d      = CH_RED;
                        tmr_d     = SETTLE_LOAD;
                        shd_sat_d = '0;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == '0) begin
                        state_d    = ST_GATE;
                        tmr_d      = GATE_LOAD;
                        edge_cnt_d = '0;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_GATE: begin
                    edge_cnt_d = edge_cnt_nxt;
                    if (edge_q && edge_cnt_q == CNT_MAX)
                        shd_sat_d[ch_q] = 1'b1;
                    if (tmr_q == '0) begin
                        shd_d[ch_q] = edge_cnt_nxt;
                        if (ch_q == CH_CLEAR) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SETTLE;
                            ch_d    = ch_q + 2'd1;
                            tmr_d   = SETTLE_LOAD;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                default: begin
                    if (continuous) begin
                        state_d   = ST_SETTLE;
                        ch_d      = CH_RED;
                        tmr_d     = SETTLE_LOAD;
                        shd_sat_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end

        // Publishing on entry to DONE makes the counts valid in the same cycle as the done pulse.
        if (state_d == ST_DONE) begin
            pub_d = shd_d;
            sat_d = shd_sat_d;
        end

        busy_d   = (state_d != ST_IDLE);
        led_en_d = busy_d;
        s0_s1_d  = busy_d ? SCALE : 2'b00;
        s2_s3_d  = busy_d ? chan_code(ch_d) : 2'b00;
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= CH_RED;
            tmr_q      <= '0;
            edge_cnt_q <= '0;
            shd_q      <= '0;
            shd_sat_q  <= '0;
            pub_q      <= '0;
            sat_q      <= '0;
            sync_q     <= '0;
            edge_q     <= 1'b0;
            s2_s3_q    <= 2'b00;
            s0_s1_q    <= 2'b00;
            led_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            tmr_q      <= tmr_d;
            edge_cnt_q <= edge_cnt_d;
            shd_q      <= shd_d;
            shd_sat_q  <= shd_sat_d;
            pub_q      <= pub_d;
            sat_q      <= sat_d;
            sync_q     <= sync_d;
            edge_q     <= edge_d;
            s2_s3_q    <= s2_s3_d;
            s0_s1_q    <= s0_s1_d;
            led_en_q   <= led_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign s2_s3     = s2_s3_q;
    assign s0_s1     = s0_s1_q;
    assign led_en    = led_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign red_cnt   = pub_q[0];
    assign green_cnt = pub_q[1];
    assign blue_cnt  = pub_q[2];
    assign clear_cnt = pub_q[3];
    assign sat       = sat_q;
endmodule

// File: tb/tb_color_scan_sequencer.sv
// Bench for color_scan_sequencer: a 16-bit and a 3-bit-count instance share stimulus; expected
// counts come from counting rising edges of the logged sensor waveform inside each gate window.
module tb_color_scan_sequencer;
    localparam int S = 4, G = 16, P = S + G;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, continuous = 1'b0, abort = 1'b0, sensor_out = 1'b0;
    logic [1:0]  s2_s3, s0_s1, s2_s3_3, s0_s1_3;
    logic        led_en, busy, done, led_en_3, busy_3, done_3;
    logic [15:0] red_cnt, green_cnt, blue_cnt, clear_cnt;
    logic [2:0]  red_3, green_3, blue_3, clear_3;
    logic [3:0]  sat, sat_3;

    int n_checks = 0, n_fail = 0, cyc = 0, mode = 0;
    logic samp [0:4095];
    logic [1:0]  codes [4] = '{2'b00, 2'b11, 2'b01, 2'b10};
    logic [67:0] pub16 = '0;
    logic [15:0] pub3 = '0;

    color_scan_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(16), .SCALE(2'b11)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .sensor_out(sensor_out), .s2_s3(s2_s3), .s0_s1(s0_s1), .led_en(led_en), .busy(busy),
        .done(done), .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
        .clear_cnt(clear_cnt), .sat(sat));

    color_scan_sequencer #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .CNT_W(3), .SCALE(2'b11)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .sensor_out(sensor_out), .s2_s3(s2_s3_3), .s0_s1(s0_s1_3), .led_en(led_en_3), .busy(busy_3),
        .done(done_3), .red_cnt(red_3), .green_cnt(green_3), .blue_cnt(blue_3),
        .clear_cnt(clear_3), .sat(sat_3));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        samp[cyc % 4096] <= sensor_out;
        cyc <= cyc + 1;
    end

    // Pattern mode: red period 2, green period 4, blue period 8, clear held low.
    initial forever begin
        @(negedge clk);
        if (mode == 0) begin
            case (s2_s3)
                2'b00:   sensor_out = cyc[0];
                2'b11:   sensor_out = cyc[1];
                2'b01:   sensor_out = cyc[2];
                default: sensor_out = 1'b0;
            endcase
        end else begin
            sensor_out = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Edge seen by the sensor in cycle k is counted if k+3 falls in that channel's gate window.
    function automatic int model_raw(input int c0, input int ch);
        int n = 0;
        for (int k = c0 + 2 + P * ch; k <= c0 + 17 + P * ch; k++)
            if (samp[k % 4096] && !samp[(k - 1) % 4096]) n++;
        return n;
    endfunction

    function automatic logic [67:0] pack16(input int r0, input int r1, input int r2, input int r3);
        return {16'(r0), 16'(r1), 16'(r2), 16'(r3), 4'b0000};
    endfunction

    function automatic logic [15:0] pack3(input int r0, input int r1, input int r2, input int r3);
        return {3'(r0 > 7 ? 7 : r0), 3'(r1 > 7 ? 7 : r1), 3'(r2 > 7 ? 7 : r2), 3'(r3 > 7 ? 7 : r3),
                r3 > 7, r2 > 7, r1 > 7, r0 > 7};
    endfunction

    task automatic start_scan(output int c0);
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, led_en, s0_s1, s2_s3, done, busy_3, led_en_3, s0_s1_3, s2_s3_3, done_3} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected all zero",
                     {busy, led_en, s0_s1, s2_s3, done, busy_3, led_en_3, s0_s1_3, s2_s3_3, done_3});
        end
        n_checks++;
        if ({red_cnt, green_cnt, blue_cnt, clear_cnt, sat, red_3, green_3, blue_3, clear_3, sat_3} !== 84'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h expected 0",
                     {red_cnt, green_cnt, blue_cnt, clear_cnt, sat, red_3, green_3, blue_3, clear_3, sat_3});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_single_scan();
        int c0, idx;
        logic [6:0]  ec;
        logic [67:0] e16;
        logic [15:0] e3;
        mode = 0;
        start_scan(c0);
        for (int r = 1; r <= 82; r++) begin
            if (r > 1) @(negedge clk);
            idx = (r - 1) / P;
            if (idx > 3) idx = 3;
            ec  = (r <= 81) ? {1'b1, 1'b1, 2'b11, codes[idx], r == 81} : 7'd0;
            e16 = (r >= 81) ? pack16(8, 4, 2, 0) : pub16;
            e3  = (r >= 81) ? pack3(8, 4, 2, 0) : pub3;
            n_checks++;
            if ({busy, led_en, s0_s1, s2_s3, done} !== ec || {busy_3, led_en_3, s0_s1_3, s2_s3_3, done_3} !== ec) begin
                n_fail++;
                $display("FAIL single_ctl r=%0d: got %b / %b expected %b", r,
                         {busy, led_en, s0_s1, s2_s3, done}, {busy_3, led_en_3, s0_s1_3, s2_s3_3, done_3}, ec);
            end
            n_checks++;
            if ({red_cnt, green_cnt, blue_cnt, clear_cnt, sat} !== e16) begin
                n_fail++;
                $display("FAIL single_cnt r=%0d: got %h expected %h", r,
                         {red_cnt, green_cnt, blue_cnt, clear_cnt, sat}, e16);
            end
            n_checks++;
            if ({red_3, green_3, blue_3, clear_3, sat_3} !== e3) begin
                n_fail++;
                $display("FAIL sat_cnt r=%0d: got %h expected %h", r, {red_3, green_3, blue_3, clear_3, sat_3}, e3);
            end
        end
        pub16 = pack16(8, 4, 2, 0);
        pub3  = pack3(8, 4, 2, 0);
    endtask

    task automatic test_abort();
        int c0;
        mode = 1;
        start_scan(c0);
        for (int r = 1; r <= 90; r++) begin
            if (r > 1) @(negedge clk);
            if (r == 51) begin
                abort = 1'b0;
                n_checks++;
                if ({busy, led_en, s0_s1, s2_s3} !== 6'd0) begin
                    n_fail++;
                    $display("FAIL abort_idle: got %b expected 000000", {busy, led_en, s0_s1, s2_s3});
                end
            end
            n_checks++;
            if (done !== 1'b0 || done_3 !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_done r=%0d: got %b%b expected 00", r, done, done_3);
            end
            n_checks++;
            if ({red_cnt, green_cnt, blue_cnt, clear_cnt, sat} !== pub16 || {red_3, green_3, blue_3, clear_3, sat_3} !== pub3) begin
                n_fail++;
                $display("FAIL abort_keep r=%0d: got %h expected %h", r,
                         {red_cnt, green_cnt, blue_cnt, clear_cnt, sat}, pub16);
            end
            if (r == 50) abort = 1'b1;
        end
    endtask

    task automatic test_continuous();
        int c0;
        mode = 0;
        continuous = 1'b1;
        start_scan(c0);
        for (int r = 1; r <= 244; r++) begin
            if (r > 1) @(negedge clk);
            if (r == 31) start = 1'b0;
            n_checks++;
            if (done !== (r == 81 || r == 162 || r == 243) || busy !== (r <= 243)) begin
                n_fail++;
                $display("FAIL cont_timing r=%0d: done %b busy %b expected done %b busy %b", r, done, busy,
                         r == 81 || r == 162 || r == 243, r <= 243);
            end
            if (r == 81 || r == 162 || r == 243) begin
                n_checks++;
                if ({red_cnt, green_cnt, blue_cnt, clear_cnt, sat} !== pack16(8, 4, 2, 0)) begin
                    n_fail++;
                    $display("FAIL cont_cnt r=%0d: got %h expected %h", r,
                             {red_cnt, green_cnt, blue_cnt, clear_cnt, sat}, pack16(8, 4, 2, 0));
                end
            end
            if (r == 30) start = 1'b1;
            if (r == 243) continuous = 1'b0;
        end
    endtask

    task automatic test_reset_mid_scan();
        int c0;
        mode = 0;
        start_scan(c0);
        for (int r = 1; r < 45; r++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy: got %b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, led_en, s0_s1, s2_s3, done, red_cnt, green_cnt, blue_cnt, clear_cnt, sat} !== 75'd0 ||
            {red_3, green_3, blue_3, clear_3, sat_3} !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h / %h expected 0",
                     {busy, led_en, s0_s1, s2_s3, done, red_cnt, green_cnt, blue_cnt, clear_cnt, sat},
                     {red_3, green_3, blue_3, clear_3, sat_3});
        end
        pub16 = '0;
        pub3  = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_scan(c0);
        for (int r = 1; r <= 82; r++) begin
            if (r > 1) @(negedge clk);
            n_checks++;
            if (done !== (r == 81) || busy !== (r <= 81)) begin
                n_fail++;
                $display("FAIL rstmid_scan r=%0d: done %b busy %b", r, done, busy);
            end
            if (r == 80 || r == 81) begin
                n_checks++;
                if ({red_cnt, green_cnt, blue_cnt, clear_cnt, sat} !== ((r == 81) ? pack16(8, 4, 2, 0) : pub16)) begin
                    n_fail++;
                    $display("FAIL rstmid_cnt r=%0d: got %h", r, {red_cnt, green_cnt, blue_cnt, clear_cnt, sat});
                end
            end
        end
        pub16 = pack16(8, 4, 2, 0);
        pub3  = pack3(8, 4, 2, 0);
    endtask

    task automatic test_random_scans();
        int c0;
        int raw [4];
        mode = 1;
        for (int s = 0; s < 4; s++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_scan(c0);
            for (int r = 1; r <= 82; r++) begin
                if (r > 1) @(negedge clk);
                n_checks++;
                if (done !== (r == 81) || busy !== (r <= 81)) begin
                    n_fail++;
                    $display("FAIL rand_timing s=%0d r=%0d: done %b busy %b", s, r, done, busy);
                end
                if (r == 80) begin
                    n_checks++;
                    if ({red_cnt, green_cnt, blue_cnt, clear_cnt, sat} !== pub16) begin
                        n_fail++;
                        $display("FAIL rand_stable s=%0d: got %h expected %h", s,
                                 {red_cnt, green_cnt, blue_cnt, clear_cnt, sat}, pub16);
                    end
                end
                if (r == 81) begin
                    for (int ch = 0; ch < 4; ch++) raw[ch] = model_raw(c0, ch);
                    pub16 = pack16(raw[0], raw[1], raw[2], raw[3]);
                    pub3  = pack3(raw[0], raw[1], raw[2], raw[3]);
                    n_checks++;
                    if ({red_cnt, green_cnt, blue_cnt, clear_cnt, sat} !== pub16) begin
                        n_fail++;
                        $display("FAIL rand_cnt s=%0d: got %h expected %h", s,
                                 {red_cnt, green_cnt, blue_cnt, clear_cnt, sat}, pub16);
                    end
                    n_checks++;
                    if ({red_3, green_3, blue_3, clear_3, sat_3} !== pub3) begin
                        n_fail++;
                        $display("FAIL rand_sat s=%0d: got %h expected %h", s,
                                 {red_3, green_3, blue_3, clear_3, sat_3}, pub3);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_abort();
        test_continuous();
        test_reset_mid_scan();
        test_random_scans();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
